// File: rtl/move_encoder_if.sv
// Board-button bundle: nine raw cell buttons plus enable in, encoded cell index and status out.
// master drives the buttons (board/bench side); slave is the encoder.
interface move_encoder_if;
  logic       enable;
  logic       btn1, btn2, btn3, btn4, btn5, btn6, btn7, btn8, btn9;
  logic [3:0] sel;
  logic       sel_valid;
  logic       multi_err;
  logic       busy;

  modport master (
    output enable, btn1, btn2, btn3, btn4, btn5, btn6, btn7, btn8, btn9,
    input  sel, sel_valid, multi_err, busy
  );

  modport slave (
    input  enable, btn1, btn2, btn3, btn4, btn5, btn6, btn7, btn8, btn9,
    output sel, sel_valid, multi_err, busy
  );
endinterface

// File: rtl/move_encoder.sv
// Synchronizes and debounces nine cell buttons and emits a one-hot-checked cell index 0..8.
// sel/sel_valid land DEBOUNCE_CYCLES+3 edges after a clean press; no backpressure, pulses are one cycle.
module move_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  move_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, WAIT_RELEASE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state;
  logic [8:0] raw;
  logic [8:0] sync1;
  logic [8:0] b;
  logic [8:0] cand;
  logic [7:0] cnt;
  logic [3:0] sel_r;
  logic       sel_valid_r;
  logic       multi_err_r;
  logic       busy_r;
  logic       none;
  logic       one_hot;

  assign raw = {bus.btn9, bus.btn8, bus.btn7, bus.btn6, bus.btn5,
                bus.btn4, bus.btn3, bus.btn2, bus.btn1};

  assign none    = (b == 9'd0);
  assign one_hot = !none && ((b & (b - 9'd1)) == 9'd0);

  function automatic logic [3:0] encode(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 9; i++)
      if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 9'd0;
      b     <= 9'd0;
    end else begin
      sync1 <= raw;
      b     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      cand        <= 9'd0;
      sel_r       <= 4'hF;
      sel_valid_r <= 1'b0;
      multi_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      sel_valid_r <= 1'b0;
      multi_err_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            if (one_hot) begin
              cand   <= b;
              cnt    <= 8'd0;
              state  <= DEBOUNCE;
              busy_r <= 1'b1;
            end else if (!none) begin
              multi_err_r <= 1'b1;
              state       <= WAIT_RELEASE;
              busy_r      <= 1'b1;
            end
          end
        end
        // Any change of b (release, bounce, extra button) outranks the counter.
        DEBOUNCE: begin
          if (b != cand) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (cnt == LAST_CNT) begin
            state       <= EMIT;
            sel_r       <= encode(cand);
            sel_valid_r <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EMIT: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (none) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = sel_r;
  assign bus.sel_valid = sel_valid_r;
  assign bus.multi_err = multi_err_r;
  assign bus.busy      = busy_r;

endmodule
